// File: rtl/fpga_test_step_udiv_pkg.sv
// Shared types and default widths for the fpga_test_step sequential unsigned divider.
package fpga_test_step_udiv_pkg;

  localparam int DIVIDEND_WIDTH_C = 30;
  localparam int DIVISOR_WIDTH_C  = 15;
  localparam int CNT_WIDTH_C      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } udiv_state_t;

  typedef struct packed {
    logic [DIVIDEND_WIDTH_C-1:0] quotient;
    logic [DIVISOR_WIDTH_C-1:0]  remainder;
    logic                        div_by_zero;
  } udiv_result_t;

endpackage

// File: rtl/fpga_test_step_udiv_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module fpga_test_step_udiv_step #(
  parameter int DIVISOR_WIDTH = 15
) (
  input  logic [DIVISOR_WIDTH:0]   partial,
  input  logic                     q_msb,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  output logic [DIVISOR_WIDTH:0]   partial_next,
  output logic                     q_bit
);

  logic [DIVISOR_WIDTH+1:0] shifted;

  assign shifted = {partial, q_msb};
  assign q_bit   = (shifted >= (DIVISOR_WIDTH+2)'(divisor));
  // A successful subtraction always leaves a value below the divisor, so the top bit drops safely.
  assign partial_next = q_bit ? (DIVISOR_WIDTH+1)'(shifted - (DIVISOR_WIDTH+2)'(divisor))
                              : shifted[DIVISOR_WIDTH:0];

endmodule

// File: rtl/fpga_test_step_udiv_30ns_15ns_seq.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock, valid/ready on both sides.
// Optional FPGA_TEST_STEP_UDIV_EARLY_EXIT_EN: dividend < divisor finishes at the accept edge.
module fpga_test_step_udiv_30ns_15ns_seq
  import fpga_test_step_udiv_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIVIDEND_WIDTH_C,
  parameter int DIVISOR_WIDTH  = DIVISOR_WIDTH_C,
  parameter int CNT_WIDTH      = CNT_WIDTH_C
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);

  udiv_state_t               state_reg, state_next;
  logic [DIVISOR_WIDTH:0]    partial_reg;
  logic [DIVIDEND_WIDTH-1:0] qsh_reg;
  logic [DIVISOR_WIDTH-1:0]  divisor_reg;
  logic [CNT_WIDTH-1:0]      cnt_reg;
  logic [DIVIDEND_WIDTH-1:0] quotient_reg;
  logic [DIVISOR_WIDTH-1:0]  remainder_reg;
  logic                      dbz_reg;

  logic [DIVISOR_WIDTH:0]    partial_step;
  logic                      qbit_step;
  logic                      last_iter;
  logic                      zero_div;
  logic                      early;

  fpga_test_step_udiv_step #(
    .DIVISOR_WIDTH(DIVISOR_WIDTH)
  ) u_step (
    .partial      (partial_reg),
    .q_msb        (qsh_reg[DIVIDEND_WIDTH-1]),
    .divisor      (divisor_reg),
    .partial_next (partial_step),
    .q_bit        (qbit_step)
  );

  assign last_iter = (cnt_reg == CNT_WIDTH'(DIVIDEND_WIDTH-1));
  assign zero_div  = (divisor == '0);

`ifdef FPGA_TEST_STEP_UDIV_EARLY_EXIT_EN
  assign early = !zero_div && (dividend < DIVIDEND_WIDTH'(divisor));
`else
  assign early = 1'b0;
`endif

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = (zero_div || early) ? DONE : BUSY;
      BUSY:    if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      partial_reg   <= '0;
      qsh_reg       <= '0;
      divisor_reg   <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            divisor_reg <= divisor;
            partial_reg <= '0;
            qsh_reg     <= dividend;
            cnt_reg     <= '0;
            if (zero_div) begin
              quotient_reg  <= '1;
              remainder_reg <= dividend[DIVISOR_WIDTH-1:0];
              dbz_reg       <= 1'b1;
            end else if (early) begin
              quotient_reg  <= '0;
              remainder_reg <= dividend[DIVISOR_WIDTH-1:0];
              dbz_reg       <= 1'b0;
            end
          end
        end
        BUSY: begin
          partial_reg <= partial_step;
          qsh_reg     <= {qsh_reg[DIVIDEND_WIDTH-2:0], qbit_step};
          cnt_reg     <= cnt_reg + CNT_WIDTH'(1);
          // Results are published only on the final iteration so IDLE keeps showing the last one.
          if (last_iter) begin
            quotient_reg  <= {qsh_reg[DIVIDEND_WIDTH-2:0], qbit_step};
            remainder_reg <= partial_step[DIVISOR_WIDTH-1:0];
            dbz_reg       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_test_step_udiv_30ns_15ns_seq.sv
// Self-checking bench for the sequential divider: directed cases plus random operands
// checked every cycle against a plain-arithmetic model of quotient, remainder and latency.
module tb_fpga_test_step_udiv_30ns_15ns_seq;
  import fpga_test_step_udiv_pkg::*;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [29:0] dividend = '0;
  logic [14:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [29:0] quotient;
  logic [14:0] remainder;
  logic        div_by_zero;

  fpga_test_step_udiv_30ns_15ns_seq dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  bit           pending = 1'b0;
  bit           seen = 1'b0;
  int           accept_cyc = 0;
  int           exp_off = 0;
  udiv_result_t exp_res = '0;
  udiv_result_t last_res = '0;
  int           op_num = 0;

  function automatic udiv_result_t model(input logic [29:0] a, input logic [14:0] b);
    udiv_result_t r;
    if (b == 15'd0) begin
      r.quotient    = '1;
      r.remainder   = a[14:0];
      r.div_by_zero = 1'b1;
    end else begin
      r.quotient    = a / 30'(b);
      r.remainder   = 15'(a % 30'(b));
      r.div_by_zero = 1'b0;
    end
    return r;
  endfunction

  // Edges between the accept edge and the edge that enters DONE.
  function automatic int model_off(input logic [29:0] a, input logic [14:0] b);
    if (b == 15'd0) return 0;
`ifdef FPGA_TEST_STEP_UDIV_EARLY_EXIT_EN
    if (a < 30'(b)) return 0;
`endif
    return 30;
  endfunction

  function automatic udiv_result_t mk(input logic [29:0] q, input logic [14:0] r, input logic z);
    udiv_result_t v;
    v.quotient = q;
    v.remainder = r;
    v.div_by_zero = z;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (!pending) chk("no_spurious_valid", 32'(out_valid), 32'd0);
      if (out_valid && pending) begin
        if (!seen) begin
          seen = 1'b1;
          chk("latency", 32'(cyc - accept_cyc), 32'(exp_off));
        end
        chk("quotient", 32'(quotient), 32'(exp_res.quotient));
        chk("remainder", 32'(remainder), 32'(exp_res.remainder));
        chk("div_by_zero", 32'(div_by_zero), 32'(exp_res.div_by_zero));
        chk("in_ready_done", 32'(in_ready), 32'd0);
      end
      if (!out_valid) begin
        chk("held_quotient", 32'(quotient), 32'(last_res.quotient));
        chk("held_remainder", 32'(remainder), 32'(last_res.remainder));
        chk("held_div_by_zero", 32'(div_by_zero), 32'(last_res.div_by_zero));
        if (pending && !seen && cyc >= accept_cyc) begin
          chk("in_ready_busy", 32'(in_ready), 32'd0);
          if (cyc - accept_cyc > exp_off) begin
            seen = 1'b1;
            chk("latency_late", 32'(cyc - accept_cyc), 32'(exp_off));
          end
        end
      end
    end
  end

  task automatic start_op(input logic [29:0] a, input logic [14:0] b, input bit use_lit,
                          input udiv_result_t lit);
    @(negedge ap_clk);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    exp_res    = use_lit ? lit : model(a, b);
    exp_off    = model_off(a, b);
    accept_cyc = cyc + 1;
    seen       = 1'b0;
    pending    = 1'b1;
    op_num++;
    $display("op %0d dividend=%0d divisor=%0d expect quotient=%0d remainder=%0d dbz=%0d latency=%0d",
             op_num, a, b, exp_res.quotient, exp_res.remainder, exp_res.div_by_zero, exp_off);
  endtask

  task automatic run_op(input logic [29:0] a, input logic [14:0] b, input int hold,
                        input bit use_lit, input udiv_result_t lit);
    int waited;
    int held;
    bit done;
    waited = 0;
    held   = 0;
    done   = 1'b0;
    start_op(a, b, use_lit, lit);
    while (!done && waited < 200) begin
      @(negedge ap_clk);
      waited++;
      in_valid = 1'($urandom);
      dividend = 30'($urandom);
      divisor  = 15'($urandom);
      if (out_valid) begin
        if (held >= hold) begin
          out_ready = 1'b1;
          last_res  = exp_res;
          done      = 1'b1;
        end else begin
          out_ready = 1'b0;
          held++;
        end
      end else begin
        out_ready = 1'($urandom);
      end
    end
    chk("result_timeout", 32'(done), 32'd1);
    if (!done) last_res = exp_res;
    @(negedge ap_clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pending   = 1'b0;
    chk("done_one_cycle", 32'(out_valid), 32'd0);
  endtask

  task automatic run_reset_mid(input logic [29:0] a, input logic [14:0] b, input int iters);
    start_op(a, b, 1'b0, '0);
    repeat (iters) begin
      @(negedge ap_clk);
      in_valid  = 1'($urandom);
      dividend  = 30'($urandom);
      divisor   = 15'($urandom);
      out_ready = 1'($urandom);
    end
    #2;
    ap_rst_n = 1'b0;
    pending  = 1'b0;
    last_res = '0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    @(negedge ap_clk);
    #2 ap_rst_n = 1'b1;
    repeat (40) @(negedge ap_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [29:0] a;
    logic [14:0] b;
    int sel;

    repeat (3) @(negedge ap_clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_div_by_zero", 32'(div_by_zero), 32'd0);
    #2 ap_rst_n = 1'b1;

    run_op(30'h3FFF0001, 15'd32767, 0, 1'b1, mk(30'd32767, 15'd0, 1'b0));
    run_op(30'd1000000, 15'd7, 5, 1'b1, mk(30'd142857, 15'd1, 1'b0));
    run_op(30'd1234, 15'd0, 0, 1'b1, mk(30'h3FFFFFFF, 15'd1234, 1'b1));
    run_op(30'd5, 15'd9, 0, 1'b1, mk(30'd0, 15'd5, 1'b0));
    run_reset_mid(30'd100, 15'd3, 10);
    run_op(30'd100, 15'd3, 0, 1'b1, mk(30'd33, 15'd1, 1'b0));
    run_op(30'h3FFFFFFF, 15'd1, 1, 1'b1, mk(30'h3FFFFFFF, 15'd0, 1'b0));

    for (int i = 0; i < 30; i++) begin
      sel = int'($urandom_range(0, 7));
      a = 30'($urandom);
      b = 15'($urandom);
      case (sel)
        0: b = 15'd0;
        1: b = 15'($urandom_range(1, 15));
        2: begin
          a = 30'($urandom_range(0, 40));
          b = 15'($urandom_range(1, 50));
        end
        3: b = 15'h7FFF;
        default: ;
      endcase
      run_op(a, b, int'($urandom_range(0, 3)), 1'b0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
